fetch_inst_queue: RTL

//  Multi-lane instruction queue between fetch and decode; successor to the single-lane fetch/decode handshake.

---
 rtl/fetch_inst_queue_pkg.sv | 10 +
 rtl/fetch_inst_queue_ram.sv | 33 +++
 rtl/fetch_inst_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_inst_queue_pkg.sv
// Shared sizing defaults for the multi-lane fetch-to-decode instruction queue.
package fetch_inst_queue_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned InstWidth  = 32;
  localparam int unsigned InstQDepth = 8;
  localparam int unsigned FetchWidth = 2;
  localparam int unsigned DecWidth   = 2;

endpackage

// File: rtl/fetch_inst_queue_ram.sv
// Queue storage: NW write ports at consecutive wrapping addresses, NR async read ports.
module fetch_inst_queue_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 64,
  parameter int unsigned NW    = 2,
  parameter int unsigned NR    = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [NW-1:0]     we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [NW*W-1:0]   wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [NR*W-1:0]   rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; validity lives in the top's count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NW); k++) begin
      if (we_i[k]) mem_q[waddr_i + AW'(k)] <= wdata_i[k*W +: W];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int r = 0; r < int'(NR); r++) begin
      rdata_o[r*W +: W] = mem_q[raddr_i + AW'(r)];
    end
  end

endmodule

// File: rtl/fetch_inst_queue.sv
// Multi-lane instruction queue between fetch and decode with back-pressure and flush.
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int unsigned ADDR        = AddrWidth,
  parameter int unsigned INST        = InstWidth,
  parameter int unsigned DEPTH       = InstQDepth,
  parameter int unsigned FETCH_WIDTH = FetchWidth,
  parameter int unsigned DEC_WIDTH   = DecWidth,
  localparam int unsigned PW         = $clog2(DEPTH),
  localparam int unsigned CW         = PW + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [FETCH_WIDTH-1:0]      fetch_e_,
  input  logic [FETCH_WIDTH*ADDR-1:0] fetch_pc,
  input  logic [FETCH_WIDTH*INST-1:0] fetch_inst,
  output logic                        fq_stall,
  output logic [DEC_WIDTH-1:0]        inst_e_,
  output logic [DEC_WIDTH*ADDR-1:0]   inst_pc,
  output logic [DEC_WIDTH*INST-1:0]   inst,
  input  logic                        dec_stall,
  output logic [CW-1:0]               fq_count
);

  localparam int unsigned EW = ADDR + INST;

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d, n_push, n_pop;
  logic                     stall_q, stall_d;
  logic [FETCH_WIDTH-1:0]   fetch_v, we;
  logic [FETCH_WIDTH*EW-1:0] wdata;
  logic [DEC_WIDTH*EW-1:0]  rdata;

  fetch_inst_queue_ram #(
    .DEPTH (DEPTH),
    .W     (EW),
    .NW    (FETCH_WIDTH),
    .NR    (DEC_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Push/pop accounting; flush overrides both and empties the queue.
  always_comb begin
    fetch_v  = ~fetch_e_;
    we       = '0;
    wdata    = '0;
    n_push   = '0;
    n_pop    = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!stall_q && !flush) we = fetch_v;
    for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
      wdata[k*EW +: EW] = {fetch_pc[k*ADDR +: ADDR], fetch_inst[k*INST +: INST]};
      n_push            = n_push + CW'(we[k]);
    end
    if (!dec_stall && !flush) begin
      n_pop = (count_q < CW'(DEC_WIDTH)) ? count_q : CW'(DEC_WIDTH);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(n_pop);
      count_d  = count_q + n_push - n_pop;
    end
    stall_d = (CW'(DEPTH) - count_d) < CW'(FETCH_WIDTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Presentation is driven purely from registered state; invalid lanes read as zero.
  always_comb begin
    inst_e_ = '1;
    inst_pc = '0;
    inst    = '0;
    for (int d = 0; d < int'(DEC_WIDTH); d++) begin
      if (count_q > CW'(d)) begin
        inst_e_[d]             = 1'b0;
        inst_pc[d*ADDR +: ADDR] = rdata[d*EW + INST +: ADDR];
        inst[d*INST +: INST]    = rdata[d*EW +: INST];
      end
    end
  end

  assign fq_stall = stall_q;
  assign fq_count = count_q;

  // Valid lanes must be contiguous from lane 0 (mask of the form 0..01..1).
  a_contig_lanes : assert property (@(posedge clk) disable iff (reset)
    ((fetch_v & (fetch_v + FETCH_WIDTH'(1))) == '0));

endmodule
